// File: rtl/efpga_fifo_drain.sv
// ---------------------------------------------------------------------------
// efpga_fifo_drain
// Read-side engine for the eFPGA dual-clock FIFO. Pops words from the FIFO
// read port and presents them on a valid/ready stream. A small skid buffer
// absorbs the fixed one-cycle RAM read latency, so the stream runs at one word
// per cycle and data_o never depends combinationally on fifo_rdata_i.
// Also sequences a one-cycle flush and counts accepted stream words.
// Everything runs in the FIFO read-clock domain.
// ---------------------------------------------------------------------------
module efpga_fifo_drain #(
    parameter int WIDTH      = 32,
    parameter int SKID_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 flush_i,
    input  logic [WIDTH-1:0]     fifo_rdata_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_pop_o,
    output logic                 fifo_flush_o,
    output logic [WIDTH-1:0]     data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_WIDTH-1:0] xfer_cnt_o,
    output logic                 busy_o
);

    // Occupancy must be able to hold the value SKID_DEPTH itself.
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = $clog2(SKID_DEPTH);

    // One extra bit so occ + inflight can never wrap before the compare.
    localparam logic [OCC_W:0]   DEPTH_CMP = (OCC_W + 1)'(SKID_DEPTH);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(SKID_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(SKID_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic                   inflight_q;
    logic [CNT_WIDTH-1:0]   cnt_q;

    logic                   handshake;
    logic                   skid_wr;
    logic                   skid_rd;
    logic [OCC_W:0]         demand;
    logic [WIDTH-1:0]       entry_rd [SKID_DEPTH];

    // Pointers wrap at SKID_DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Skid-buffer storage: one register slot per entry
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_skid
        logic [WIDTH-1:0] entry_q;
        logic             entry_we;

        assign entry_we = skid_wr && (wr_ptr_q == PTR_W'(gi));

        // Capture returning read data when this slot is the tail
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                entry_q <= '0;
            end else if (entry_we) begin
                entry_q <= fifo_rdata_i;
            end
        end

        assign entry_rd[gi] = entry_q;
    end

    // ------------------------------------------------------------------
    // Stream side: head of the skid buffer, registers only
    // ------------------------------------------------------------------
    assign valid_o    = (occ_q != '0);
    assign data_o     = entry_rd[rd_ptr_q];
    assign handshake  = valid_o & ready_i;
    assign xfer_cnt_o = cnt_q;
    assign busy_o     = valid_o | inflight_q | (state_q == ST_FLUSH);

    // Words already committed to the skid buffer after this cycle's handshake.
    // A handshake implies occ >= 1, so the subtraction never underflows.
    assign demand = {1'b0, occ_q}
                  + {{OCC_W{1'b0}}, inflight_q}
                  - {{OCC_W{1'b0}}, handshake};

    // Pop only while running, with data available and room guaranteed
    assign fifo_pop_o = (state_q == ST_RUN) && !fifo_empty_i && (demand < DEPTH_CMP);

    // Returning data is dropped while flushing or when a flush is being taken
    assign skid_wr = inflight_q && (state_q != ST_FLUSH) && !flush_i;
    assign skid_rd = handshake;

    // ------------------------------------------------------------------
    // Control FSM: next state and flush pulse
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        fifo_flush_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable_i) state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                fifo_flush_o = 1'b1;
                state_d      = enable_i ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A flush request overrides every other transition
        if (flush_i) state_d = ST_FLUSH;
    end

    // Skid pointer and occupancy bookkeeping; a flush empties the buffer
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (skid_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (skid_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
            if (skid_wr && !skid_rd) begin
                occ_d = occ_q + 1'b1;
            end else if (!skid_wr && skid_rd) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    // State, pointers, in-flight flag and transfer counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= fifo_pop_o;
            if (handshake) cnt_q <= cnt_q + 1'b1;
        end
    end

    // The pop rule must make it impossible to write into a full skid buffer
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(skid_wr && !skid_rd && (occ_q == OCC_FULL)));

endmodule

// File: tb/tb_efpga_fifo_drain.sv
// ---------------------------------------------------------------------------
// Bench for efpga_fifo_drain: a queue-based FIFO model feeds the DUT, and a
// behavioural scoreboard predicts every output each cycle from the stream
// rules (words in flight, words buffered, mode derived from last cycle's
// enable/flush). Directed scenarios are followed by a random phase.
// ---------------------------------------------------------------------------
module tb_efpga_fifo_drain;
    localparam int WIDTH = 32;
    localparam int SKID  = 2;
    localparam int CW    = 4;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic             enable     = 1'b0;
    logic             flush      = 1'b0;
    logic             fifo_empty = 1'b1;
    logic             ready      = 1'b0;
    logic [WIDTH-1:0] fifo_rdata = '0;
    logic             fifo_pop;
    logic             fifo_flush;
    logic             valid;
    logic             busy;
    logic [WIDTH-1:0] data;
    logic [CW-1:0]    xfer_cnt;

    always #5 clk = ~clk;

    efpga_fifo_drain #(
        .WIDTH      (WIDTH),
        .SKID_DEPTH (SKID),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .enable_i     (enable),
        .flush_i      (flush),
        .fifo_rdata_i (fifo_rdata),
        .fifo_empty_i (fifo_empty),
        .fifo_pop_o   (fifo_pop),
        .fifo_flush_o (fifo_flush),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .xfer_cnt_o   (xfer_cnt),
        .busy_o       (busy)
    );

    typedef enum int {M_IDLE, M_RUN, M_FLUSH} mstate_t;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] skid_m[$];
    bit               pend_valid;
    logic [WIDTH-1:0] pend_word;
    mstate_t          st_m;
    int               cnt_m;
    int               cyc;
    int               pop_cyc[$];
    int               hs_cyc[$];
    int               flush_cycles;
    bit               prev_stall;
    logic [WIDTH-1:0] prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        fifo_q.delete();
        skid_m.delete();
        pend_valid   = 1'b0;
        pend_word    = '0;
        st_m         = M_IDLE;
        cnt_m        = 0;
        cyc          = 0;
        pop_cyc.delete();
        hs_cyc.delete();
        flush_cycles = 0;
        prev_stall   = 1'b0;
        prev_data    = '0;
        fifo_empty   = 1'b1;
    endtask

    task automatic enter_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        flush  = 1'b0;
        ready  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_clear();
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic load(input int n, input logic [WIDTH-1:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(rnd ? WIDTH'($urandom()) : base + WIDTH'(i));
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    // One clock cycle: predict and compare outputs, then advance both models
    task automatic cycle();
        bit               e_valid, e_hs, e_pop, e_flush, e_busy;
        bit               a_pop, a_flush;
        logic [WIDTH-1:0] word;
        #1;
        e_valid = (skid_m.size() != 0);
        e_flush = (st_m == M_FLUSH);
        e_hs    = e_valid && ready;
        e_pop   = (st_m == M_RUN) && (fifo_q.size() != 0)
                  && ((skid_m.size() + int'(pend_valid) - int'(e_hs)) < SKID);
        e_busy  = e_valid || pend_valid || e_flush;
        check("valid_o", 32'(valid), 32'(e_valid));
        if (e_valid) check("data_o", data, skid_m[0]);
        check("fifo_pop_o", 32'(fifo_pop), 32'(e_pop));
        check("fifo_flush_o", 32'(fifo_flush), 32'(e_flush));
        check("busy_o", 32'(busy), 32'(e_busy));
        check("xfer_cnt_o", 32'(xfer_cnt), 32'(cnt_m % 16));
        check("pop_when_empty", 32'(fifo_pop && fifo_empty), 32'd0);
        if (prev_stall) begin
            check("stall_valid", 32'(valid), 32'd1);
            check("stall_data", data, prev_data);
        end
        a_pop   = fifo_pop;
        a_flush = fifo_flush;
        if (a_pop) pop_cyc.push_back(cyc);
        if (valid && ready) hs_cyc.push_back(cyc);
        if (a_flush) flush_cycles++;
        prev_stall = valid && !ready && !flush;
        prev_data  = data;
        @(posedge clk);
        if (e_hs) begin
            void'(skid_m.pop_front());
            cnt_m++;
        end
        if (pend_valid && st_m != M_FLUSH) skid_m.push_back(pend_word);
        if (flush) skid_m.delete();
        check("skid_bound", 32'((skid_m.size() + int'(a_pop)) <= SKID), 32'd1);
        word = '0;
        if (a_pop && fifo_q.size() != 0) word = fifo_q.pop_front();
        pend_valid = a_pop;
        pend_word  = word;
        if (a_flush) fifo_q.delete();
        st_m = flush ? M_FLUSH : (enable ? M_RUN : M_IDLE);
        #1;
        fifo_rdata = pend_valid ? pend_word : WIDTH'($urandom());
        fifo_empty = (fifo_q.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        // Reset with the FIFO preloaded: nothing may move
        enter_reset();
        load(8, 32'h10, 1'b0);
        enable = 1'b1;
        ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_pop", 32'(fifo_pop), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flush", 32'(fifo_flush), 32'd0);
        check("rst_data", data, 32'd0);
        @(negedge clk);

        // Streaming: pops on consecutive cycles, data two cycles later
        release_reset();
        repeat (14) cycle();
        check("stream_pops", 32'(pop_cyc.size()), 32'd8);
        check("stream_hs", 32'(hs_cyc.size()), 32'd8);
        for (int i = 0; i < 8 && i < pop_cyc.size() && i < hs_cyc.size(); i++) begin
            check("stream_pop_cycle", 32'(pop_cyc[i]), 32'(1 + i));
            check("stream_hs_cycle", 32'(hs_cyc[i]), 32'(3 + i));
        end
        check("stream_cnt", 32'(xfer_cnt), 32'd8);

        // Backpressure with ready pattern 1,0,0
        enter_reset();
        load(8, '0, 1'b1);
        release_reset();
        enable = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ready = (k % 3 == 0);
            cycle();
        end
        check("bp_hs", 32'(hs_cyc.size()), 32'd8);
        check("bp_cnt", 32'(xfer_cnt), 32'd8);
        check("bp_busy", 32'(busy), 32'd0);

        // Flush mid-stream, pulsed in the cycle of the second handshake
        enter_reset();
        load(6, 32'h40, 1'b0);
        release_reset();
        enable = 1'b1;
        ready  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (cnt_m == 1 && skid_m.size() != 0) break;
            cycle();
        end
        check("flush_setup", 32'(cnt_m == 1 && skid_m.size() != 0), 32'd1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (10) cycle();
        check("flush_pulses", 32'(flush_cycles), 32'd1);
        check("flush_hs", 32'(hs_cyc.size()), 32'd2);
        check("flush_cnt", 32'(xfer_cnt), 32'd2);
        check("flush_pops", 32'(pop_cyc.size()), 32'd4);
        check("flush_busy", 32'(busy), 32'd0);

        // Enable drop with one word buffered and one in flight
        enter_reset();
        load(8, 32'h80, 1'b0);
        release_reset();
        enable = 1'b1;
        ready  = 1'b0;
        cycle();
        cycle();
        enable = 1'b0;
        cycle();
        check("endrop_busy_mid", 32'(busy), 32'd1);
        ready = 1'b1;
        repeat (10) cycle();
        check("endrop_pops", 32'(pop_cyc.size()), 32'd2);
        check("endrop_cnt", 32'(xfer_cnt), 32'd2);
        check("endrop_busy", 32'(busy), 32'd0);
        check("endrop_left", 32'(fifo_q.size()), 32'd6);

        // Counter wrap at 4 bits, then asynchronous reset mid-burst
        enter_reset();
        load(17, '0, 1'b1);
        release_reset();
        enable = 1'b1;
        ready  = 1'b1;
        repeat (25) cycle();
        check("wrap_hs", 32'(hs_cyc.size()), 32'd17);
        check("wrap_cnt", 32'(xfer_cnt), 32'd1);
        load(10, '0, 1'b1);
        repeat (5) cycle();
        check("pre_reset_valid", 32'(valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pop", 32'(fifo_pop), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_data", data, 32'd0);
        check("arst_cnt", 32'(xfer_cnt), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_flush", 32'(fifo_flush), 32'd0);

        // Random traffic: writes, ready, enable and occasional flushes
        enter_reset();
        release_reset();
        for (int k = 0; k < 400; k++) begin
            if (($urandom() % 4 == 0) && fifo_q.size() < 16) begin
                fifo_q.push_back(WIDTH'($urandom()));
                fifo_empty = 1'b0;
            end
            ready  = ($urandom() % 3) != 0;
            enable = ($urandom() % 10) != 0;
            flush  = ($urandom() % 40) == 0;
            cycle();
        end
        flush  = 1'b0;
        enable = 1'b0;
        ready  = 1'b1;
        repeat (10) cycle();
        check("rand_busy_end", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
